uart_tx: RTL
============

Name: uart_tx

Overview:
- UART transmitter, 8N-with-parity framing: 1 start bit, 8 data bits LSB first, 1 even-parity bit, 1 stop bit.
- Bytes are accepted through a valid/ready handshake into a small internal FIFO, so the host can queue several bytes and frames go out back-to-back with no idle gap.
- Sits between host logic on the board clock and the FPGA tx pin; it is the transmit-side counterpart of the team's UART receiver.

Parameters:
- CLOCK_RATE, 100000000, system clock frequency in Hz.
- BAUD_RATE, 115200, line bit rate in bits/s.
- FIFO_DEPTH, 4, number of queued bytes; power of two, minimum 2.
- CLKS_PER_BIT (derived, not overridable), CLOCK_RATE / BAUD_RATE using integer division; must be at least 2.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- data  input  8  byte to transmit.
- valid  input  1  data is valid this cycle.
- ready  output  1  FIFO can accept a byte; high when not full.
- tx  output  1  serial line; idle high; driven from a flop.
- busy  output  1  high while a frame is on the line or the FIFO is non-empty.
- tx_done  output  1  one-cycle pulse on the last clk of each stop bit.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Outputs: tx=1, ready=1, busy=0, tx_done=0.
  - Internal: FIFO pointers and count=0, state=IDLE, bit counter=0, bit index=0.
  - Reset mid-frame aborts the frame immediately (tx returns to 1) and discards all queued bytes.
- Handshake:
  - A byte is written when valid && ready at a rising edge.
  - ready = (count != FIFO_DEPTH), from registered count.
  - valid while full is ignored; the byte is dropped; no error flag.
  - Simultaneous write and pop on the same edge: count is unchanged, both take effect.
  - FIFO pointers wrap modulo FIFO_DEPTH.
- State machine (one state per bit period): IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. If FIFO is non-empty: pop the head into shift register, compute parity = XOR of the 8 bits, go to START. tx goes low on the edge after the pop, so latency from an accepted write into an empty idle block to tx falling is 2 clks.
  - START: tx=0 for CLKS_PER_BIT clks, then go to DATA.
  - DATA: tx=shift[0]; after each CLKS_PER_BIT clks, shift right and increment the bit index. After index 7 completes, go to PARITY.
  - PARITY: tx=parity bit (even parity: total 1s across data+parity is even) for CLKS_PER_BIT clks.
  - STOP: tx=1 for CLKS_PER_BIT clks. tx_done=1 on the final clk.
    - If the FIFO is non-empty at that clk: pop and go directly to START (no idle bit).
    - Otherwise go to IDLE.
  - Illegal state encoding: go to IDLE, tx=1.
- Timing:
  - Bit counter counts 0..CLKS_PER_BIT-1; the bit boundary is at CLKS_PER_BIT-1.
  - Each bit lasts exactly CLKS_PER_BIT clks; a frame lasts exactly 11*CLKS_PER_BIT clks.
  - No cumulative drift across back-to-back frames.
- busy = (state != IDLE) || (count != 0), registered.
- A write into the FIFO during a frame never disturbs the frame in flight; the shift register is loaded only on pop.

Test Plan:
- Reset values: hold rst_n=0 for 5 clks, then release -> tx=1, ready=1, busy=0, tx_done=0. Assert rst_n mid-DATA -> tx=1 within the same cycle; busy=0; no further frame transmitted.
- Single frame 0x55 (CLOCK_RATE=1000000, BAUD_RATE=100000, so CLKS_PER_BIT=10):
  - One write -> tx falls 2 clks later.
  - Sampled bit sequence 0,1,0,1,0,1,0,1,0,0,1, each bit exactly 10 clks.
  - tx_done pulses once at clk 110 of the frame.
- Parity: byte 0x01 -> parity bit 1; byte 0xFF -> parity bit 0; byte 0x00 -> parity bit 0. Check across a decoded frame.
- Back-to-back: write 0xA5, 0x3C, 0x0F on consecutive clks -> three contiguous frames of 330 clks total with no idle bit between them. Decoded bytes in order: A5, 3C, 0F. busy stays high throughout and falls 1 clk after the last tx_done.
- FIFO full: with the line busy, write 5 bytes with FIFO_DEPTH=4.
  - ready=0 after the 4th write is accepted; the 5th byte is dropped.
  - ready returns to 1 on the clk after the first pop.
  - Only the 4 accepted bytes plus the one in flight appear on tx.
- Simultaneous write and pop: write while at the STOP boundary with count=FIFO_DEPTH-1 -> count unchanged, byte order preserved, no loss.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: 8-data, even-parity, 1-stop UART transmitter fed by a small byte FIFO.
// Rev 1.0
`default_nettype none

module uart_tx #(
  parameter int CLOCK_RATE = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE;
  localparam int c_cnt_w      = $clog2(CLKS_PER_BIT);
  localparam int c_ptr_w      = $clog2(FIFO_DEPTH);
  localparam int c_fcnt_w     = $clog2(FIFO_DEPTH + 1);

  localparam logic [c_cnt_w-1:0]  c_bit_last  = c_cnt_w'(CLKS_PER_BIT - 1);
  localparam logic [c_fcnt_w-1:0] c_fifo_full = c_fcnt_w'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  logic [7:0]          r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]  r_wr_ptr;
  logic [c_ptr_w-1:0]  r_rd_ptr;
  logic [c_fcnt_w-1:0] r_count;

  state_t              r_state;
  logic [c_cnt_w-1:0]  r_bit_cnt;
  logic [2:0]          r_bit_idx;
  logic [7:0]          r_shift;
  logic                r_parity;
  logic                r_tx;
  logic                r_tx_done;
  logic                r_busy;

  state_t              w_state_next;
  logic [c_cnt_w-1:0]  w_bit_cnt_next;
  logic [2:0]          w_bit_idx_next;
  logic [7:0]          w_shift_next;
  logic                w_parity_next;
  logic                w_tx_next;
  logic                w_tx_done_next;
  logic                w_pop;
  logic                w_wr;
  logic                w_fifo_empty;
  logic                w_bit_end;
  logic [7:0]          w_head;

  assign ready        = (r_count != c_fifo_full);
  assign w_wr         = valid && ready;
  assign w_fifo_empty = (r_count == '0);
  assign w_head       = r_mem[r_rd_ptr];
  assign w_bit_end    = (r_bit_cnt == c_bit_last);

  assign tx      = r_tx;
  assign busy    = r_busy;
  assign tx_done = r_tx_done;

  // Storage needs no reset: only entries covered by r_count are ever read.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_wr && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_wr && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_tx      <= 1'b1;
      r_tx_done <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
      r_parity  <= w_parity_next;
      r_tx      <= w_tx_next;
      r_tx_done <= w_tx_done_next;
      r_busy    <= (r_state != S_IDLE) || (r_count != '0);
    end
  end

  // tx is the registered image of the current state, so the line lags the
  // state by one clk; every bit still lasts exactly CLKS_PER_BIT clks.
  always_comb begin
    w_state_next   = r_state;
    w_bit_cnt_next = w_bit_end ? '0 : r_bit_cnt + 1'b1;
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_parity_next  = r_parity;
    w_tx_next      = 1'b1;
    w_tx_done_next = 1'b0;
    w_pop          = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_bit_cnt_next = '0;
        if (!w_fifo_empty) begin
          w_pop          = 1'b1;
          w_shift_next   = w_head;
          w_parity_next  = ^w_head;
          w_bit_idx_next = '0;
          w_state_next   = S_START;
        end
      end
      S_START: begin
        w_tx_next = 1'b0;
        if (w_bit_end) begin
          w_bit_idx_next = '0;
          w_state_next   = S_DATA;
        end
      end
      S_DATA: begin
        w_tx_next = r_shift[0];
        if (w_bit_end) begin
          w_shift_next   = {1'b0, r_shift[7:1]};
          w_bit_idx_next = r_bit_idx + 1'b1;
          if (r_bit_idx == 3'd7) begin
            w_state_next = S_PARITY;
          end
        end
      end
      S_PARITY: begin
        w_tx_next = r_parity;
        if (w_bit_end) begin
          w_state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_tx_done_next = 1'b1;
          if (!w_fifo_empty) begin
            w_pop          = 1'b1;
            w_shift_next   = w_head;
            w_parity_next  = ^w_head;
            w_bit_idx_next = '0;
            w_state_next   = S_START;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: begin
        w_bit_cnt_next = '0;
        w_state_next   = S_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire
